// File: rtl/line_rasterizer_if.sv
// line_rasterizer_if: line command in, pixel-write stream out
interface line_rasterizer_if #(parameter int X_W = 10, parameter int Y_W = 9, parameter int COL_W = 8);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [X_W-1:0]   cmd_x0;
    logic [Y_W-1:0]   cmd_y0;
    logic [X_W-1:0]   cmd_x1;
    logic [Y_W-1:0]   cmd_y1;
    logic [COL_W-1:0] cmd_color;
    logic             pix_valid;
    logic             pix_ready;
    logic [X_W-1:0]   pix_x;
    logic [Y_W-1:0]   pix_y;
    logic [COL_W-1:0] pix_color;
    logic             pix_last;
    modport master (
        output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, pix_ready,
        input  cmd_ready, pix_valid, pix_x, pix_y, pix_color, pix_last
    );
    modport slave (
        input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, pix_ready,
        output cmd_ready, pix_valid, pix_x, pix_y, pix_color, pix_last
    );
endinterface

// File: rtl/line_rasterizer.sv
// line_rasterizer: Bresenham engine turning one line command into a pixel-write stream
module line_rasterizer #(parameter int X_W = 10, parameter int Y_W = 9, parameter int COL_W = 8) (
    input  logic clk,
    input  logic rst_n,
    line_rasterizer_if.slave bus,
    output logic busy
);
    localparam int W = (X_W > Y_W ? X_W : Y_W) + 2;
    typedef enum logic [1:0] {IDLE, INIT, DRAW} state_t;
    state_t state, state_nx;
    logic [X_W-1:0] x0, x1, x;
    logic [Y_W-1:0] y0, y1, y;
    logic [COL_W-1:0] color;
    logic signed [W-1:0] dx, dy, err, e2, ddx, ddy, adx, ady;
    logic sx, sy, last, fire, step_x, step_y;
    always_comb begin
        ddx = signed'(W'(x1)) - signed'(W'(x0));
        ddy = signed'(W'(y1)) - signed'(W'(y0));
        adx = ddx < 0 ? -ddx : ddx;
        ady = ddy < 0 ? -ddy : ddy;
        e2 = err <<< 1;
        step_x = e2 >= dy;
        step_y = e2 <= dx;
        last = x == x1 && y == y1;
        fire = state == DRAW && bus.pix_ready;
        state_nx = state == IDLE ? (bus.cmd_valid ? INIT : IDLE) :
                   state == INIT ? DRAW : (fire && last) ? IDLE : DRAW;
    end
    assign bus.cmd_ready = state == IDLE;
    assign bus.pix_valid = state == DRAW;
    assign bus.pix_last  = state == DRAW && last;
    assign bus.pix_x     = x;
    assign bus.pix_y     = y;
    assign bus.pix_color = color;
    assign busy          = state != IDLE;
    always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nx;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x0 <= '0;
            y0 <= '0;
            x1 <= '0;
            y1 <= '0;
            x <= '0;
            y <= '0;
            color <= '0;
            dx <= '0;
            dy <= '0;
            err <= '0;
            sx <= 1'b0;
            sy <= 1'b0;
        end else if (state == IDLE && bus.cmd_valid) begin
            x0 <= bus.cmd_x0;
            y0 <= bus.cmd_y0;
            x1 <= bus.cmd_x1;
            y1 <= bus.cmd_y1;
            color <= bus.cmd_color;
        end else if (state == INIT) begin
            dx <= adx;
            dy <= -ady;
            err <= adx - ady;
            sx <= !(x0 < x1);
            sy <= !(y0 < y1);
            x <= x0;
            y <= y0;
        end else if (fire && !last) begin
            // both tests use the pre-update err; their contributions add
            err <= err + (step_x ? dy : '0) + (step_y ? dx : '0);
            x <= step_x ? (sx ? x - X_W'(1) : x + X_W'(1)) : x;
            y <= step_y ? (sy ? y - Y_W'(1) : y + Y_W'(1)) : y;
        end
    end
endmodule
